// File: rtl/mult_div_unit.sv
// Multiply/divide unit with HI/LO result registers.
//
// Accepts MULT/MULTU/DIV/DIVU from idle. The result is computed at the accepting edge and held
// in a pending register. HI/LO are written after a fixed busy period that models a multi-cycle
// datapath. MTHI/MTLO write HI/LO directly from idle and never assert busy.
//
// Ports:
//   clk    - clock; all state changes on its rising edge
//   reset  - asynchronous active-low reset
//   start  - operation request, sampled at posedge clk
//   op     - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved
//   a      - operand rs
//   b      - operand rt
//   busy   - multi-cycle operation in progress
//   hi     - HI register
//   lo     - LO register
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpDiv   = 3'b010;
  localparam logic [2:0] OpDivu  = 3'b011;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;

  typedef enum logic {StIdle, StBusy} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [63:0]     pend_q, pend_d;
  // Clear when the pending result must not be committed (divide by zero).
  logic            wr_q, wr_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;

  // ---------------------------------------------------------------------------------------------
  // Datapath: evaluated from the current operands; only used at the accepting edge.
  // ---------------------------------------------------------------------------------------------
  logic        is_signed;
  logic [63:0] mul_a_ext, mul_b_ext, product;
  logic        a_neg, b_neg, div_by_zero;
  logic [31:0] ua, ub, uq, ur, quot, rem;

  // op[0] is 0 for the signed variants of both MULT and DIV.
  assign is_signed = ~op[0];

  // The low 64 bits of the product of sign-extended operands equal the signed 32x32 product,
  // so one multiplier serves both MULT and MULTU.
  assign mul_a_ext = {{32{is_signed & a[31]}}, a};
  assign mul_b_ext = {{32{is_signed & b[31]}}, b};
  assign product   = mul_a_ext * mul_b_ext;

  // Divide on magnitudes, then fix signs: quotient truncates toward zero and the remainder
  // follows the dividend. 0x80000000 / -1 falls out as 0x80000000 rem 0 without a special case.
  assign a_neg       = is_signed & a[31];
  assign b_neg       = is_signed & b[31];
  assign ua          = a_neg ? (32'd0 - a) : a;
  assign ub          = b_neg ? (32'd0 - b) : b;
  assign div_by_zero = (b == 32'd0);
  assign uq          = div_by_zero ? 32'd0 : (ua / ub);
  assign ur          = div_by_zero ? 32'd0 : (ua % ub);
  assign quot        = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
  assign rem         = a_neg ? (32'd0 - ur) : ur;

  // ---------------------------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pend_q  <= '0;
      wr_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      wr_q    <= wr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    wr_d    = wr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          case (op)
            OpMult, OpMultu: begin
              pend_d  = product;
              wr_d    = 1'b1;
              cnt_d   = CntW'(MULT_CYCLES);
              state_d = StBusy;
            end
            OpDiv, OpDivu: begin
              pend_d  = {rem, quot};
              wr_d    = ~div_by_zero;
              cnt_d   = CntW'(DIV_CYCLES);
              state_d = StBusy;
            end
            OpMthi:  hi_d = a;
            OpMtlo:  lo_d = a;
            default: ;
          endcase
        end
      end

      StBusy: begin
        // Requests arriving while busy (including on the completion edge) are dropped.
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q <= CntW'(1)) begin
          cnt_d   = '0;
          state_d = StIdle;
          if (wr_q) begin
            hi_d = pend_q[63:32];
            lo_d = pend_q[31:0];
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Outputs: all straight from registers, no path from start.
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    busy = (state_q == StBusy);
    hi   = hi_q;
    lo   = lo_q;
  end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  localparam int MultCycles = 5;
  localparam int DivCycles  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  int vectors     = 0;
  int miscompares = 0;

  // Scoreboard: expected {hi, lo} and busy length for each accepted multi-cycle op.
  logic [63:0] sb_q[$];
  int          len_q[$];
  logic [31:0] exp_hi, exp_lo;

  always #5 clk = ~clk;

  mult_div_unit #(
    .MULT_CYCLES(MultCycles),
    .DIV_CYCLES (DivCycles)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x,
                                        input logic [31:0] y, input logic [31:0] h,
                                        input logic [31:0] l);
    logic signed [63:0] sx, sy, sq, sr;
    logic [63:0] ux, uy;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      3'd0: return sx * sy;
      3'd1: return ux * uy;
      3'd2: begin
        if (y == 32'd0) return {h, l};
        sq = sx / sy;
        sr = sx % sy;
        return {sr[31:0], sq[31:0]};
      end
      3'd3: begin
        if (y == 32'd0) return {h, l};
        return {(x % y), (x / y)};
      end
      default: return {h, l};
    endcase
  endfunction

  // Drive one start pulse on the negedge; update the model for what the DUT should accept.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] r;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    case (o)
      3'd0, 3'd1, 3'd2, 3'd3: begin
        r = model(o, x, y, exp_hi, exp_lo);
        sb_q.push_back(r);
        len_q.push_back((o[1]) ? DivCycles : MultCycles);
        exp_hi = r[63:32];
        exp_lo = r[31:0];
      end
      3'd4: exp_hi = x;
      3'd5: exp_lo = x;
      default: ;
    endcase
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  // Count busy cycles, bounded; returns on the first negedge with busy low.
  task automatic wait_done(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    op    = 3'd0;
    a     = '0;
    b     = '0;
    #3 reset = 1'b0;
    #1;
    vectors++;
    if ({busy, hi, lo} !== 65'd0) begin
      miscompares++;
      $display("FAIL reset: busy/hi/lo=%b/%h/%h required 0/0/0", busy, hi, lo);
    end
    exp_hi = '0;
    exp_lo = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_ops(input string name, input logic [2:0] ops[], input logic [31:0] xs[],
                          input logic [31:0] ys[]);
    int n;
    logic [63:0] e;
    int el;
    for (int i = 0; i < ops.size(); i++) begin
      issue(ops[i], xs[i], ys[i]);
      wait_done(n);
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL %s[%0d]: scoreboard empty", name, i);
        continue;
      end
      e  = sb_q.pop_front();
      el = len_q.pop_front();
      if (n !== el || hi !== e[63:32] || lo !== e[31:0]) begin
        miscompares++;
        $display("FAIL %s[%0d] op=%0d a=%h b=%h: busy=%0d hi=%h lo=%h, required busy=%0d hi=%h lo=%h",
                 name, i, ops[i], xs[i], ys[i], n, hi, lo, el, e[63:32], e[31:0]);
      end
    end
  endtask

  task automatic test_mult();
    logic [2:0]  o[] = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd0, 3'd1};
    logic [31:0] x[] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000,
                         $urandom, $urandom};
    logic [31:0] y[] = '{32'h0000_0002, 32'h0000_0002, 32'h8000_0000, 32'hFFFF_FFFF,
                         $urandom, $urandom};
    test_ops("mult", o, x, y);
  endtask

  task automatic test_div();
    logic [2:0]  o[] = '{3'd2, 3'd3, 3'd2, 3'd2, 3'd3, 3'd2, 3'd2};
    logic [31:0] x[] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'd7, 32'hFFFF_FFF9,
                         32'h1234_5678, $urandom};
    logic [31:0] y[] = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd3, 32'd0,
                         32'hFFFF_FF00};
    test_ops("div", o, x, y);
  endtask

  // MTHI, then a MULT whose busy window is flooded with requests and operand toggles,
  // including a request on the completion edge.
  task automatic test_mthi_ignore();
    int n;
    logic [63:0] e;
    issue(3'd4, 32'h1234_5678, 32'd0);
    vectors++;
    if (hi !== 32'h1234_5678 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mthi: hi=%h busy=%b required hi=12345678 busy=0", hi, busy);
    end
    issue(3'd5, 32'hCAFE_F00D, 32'd0);
    vectors++;
    if (lo !== 32'hCAFE_F00D || hi !== 32'h1234_5678 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mtlo: hi=%h lo=%h busy=%b required 12345678/cafef00d/0", hi, lo, busy);
    end
    issue(3'd0, 32'h0001_0003, 32'hFFFF_FFFD);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      vectors++;
      if (hi !== 32'h1234_5678 || lo !== 32'hCAFE_F00D) begin
        miscompares++;
        $display("FAIL hold_during_busy: hi=%h lo=%h required 12345678/cafef00d", hi, lo);
      end
      start = 1'b1;
      op    = (n % 3 == 0) ? 3'd1 : ((n % 3 == 1) ? 3'd4 : 3'd5);
      a     = $urandom;
      b     = $urandom;
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    e = sb_q.pop_front();
    void'(len_q.pop_front());
    vectors++;
    if (n !== MultCycles || hi !== e[63:32] || lo !== e[31:0]) begin
      miscompares++;
      $display("FAIL busy_ignore: busy=%0d hi=%h lo=%h required busy=%0d hi=%h lo=%h",
               n, hi, lo, MultCycles, e[63:32], e[31:0]);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
      miscompares++;
      $display("FAIL completion_start: busy=%b hi=%h lo=%h required 0/%h/%h",
               busy, hi, lo, exp_hi, exp_lo);
    end
  endtask

  task automatic test_reserved();
    for (int k = 6; k < 8; k++) begin
      issue(3'(k), 32'hDEAD_BEEF, 32'h1);
      vectors++;
      if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
        miscompares++;
        $display("FAIL reserved op=%0d: busy=%b hi=%h lo=%h required 0/%h/%h",
                 k, busy, hi, lo, exp_hi, exp_lo);
      end
    end
  endtask

  task automatic test_reset_abort();
    issue(3'd2, 32'd1000, 32'd7);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    vectors++;
    if ({busy, hi, lo} !== 65'd0) begin
      miscompares++;
      $display("FAIL reset_async: busy/hi/lo=%b/%h/%h required 0/0/0", busy, hi, lo);
    end
    sb_q.delete();
    len_q.delete();
    exp_hi = '0;
    exp_lo = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    vectors++;
    if ({busy, hi, lo} !== 65'd0) begin
      miscompares++;
      $display("FAIL reset_abort: busy/hi/lo=%b/%h/%h required 0/0/0", busy, hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  o[] = new[8];
    logic [31:0] x[] = new[8];
    logic [31:0] y[] = new[8];
    for (int i = 0; i < 8; i++) begin
      o[i] = 3'($urandom_range(0, 3));
      x[i] = $urandom;
      y[i] = (i == 5) ? 32'd0 : ((i % 2) ? 32'($urandom_range(1, 300)) : $urandom);
    end
    test_ops("back_to_back", o, x, y);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mthi_ignore();
    test_reserved();
    test_reset_abort();
    begin
      logic [2:0]  o[] = '{3'd0};
      logic [31:0] x[] = '{32'h0000_1234};
      logic [31:0] y[] = '{32'hFFFF_0000};
      test_ops("after_reset", o, x, y);
    end
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: number of busy cycles for MULT/MULTU.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: number of busy cycles for DIV/DIVU.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request from the E-stage pipeline register; sampled at posedge clk.
REQ-006 SHALL have port op  input  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved.
REQ-007 SHALL have port a  input  32  operand rs.
REQ-008 SHALL have port b  input  32  operand rt.
REQ-009 SHALL have port busy  output  1  operation in progress; upstream drives pipeline-register enable low and inserts a bubble.
REQ-010 SHALL have port hi  output  32  HI register.
REQ-011 SHALL have port lo  output  32  LO register.

Function
REQ-012 SHALL implement a two-state FSM: IDLE and BUSY, plus a down-counter sized to hold max(MULT_CYCLES, DIV_CYCLES).
REQ-013 In IDLE, start=1 with op MULT/MULTU SHALL, at that edge, capture the 64-bit product in an internal pending register, load counter=MULT_CYCLES, and enter BUSY.
REQ-014 In IDLE, start=1 with op DIV/DIVU SHALL likewise capture {remainder, quotient}, load counter=DIV_CYCLES, and enter BUSY.
REQ-015 busy SHALL equal (state==BUSY), registered with no combinational path from start; it is high for exactly N consecutive cycles after the start edge.
REQ-016 In BUSY, counter SHALL decrement each edge; at the edge where counter==1 the unit SHALL write hi<=pending[63:32], lo<=pending[31:0], and return to IDLE.
REQ-017 New hi/lo SHALL be visible in the first cycle with busy=0; hi/lo SHALL hold their old values throughout BUSY.
REQ-018 MULT SHALL form a signed 32x32->64 product; MULTU SHALL form an unsigned product.
REQ-019 DIV SHALL produce a signed quotient rounded toward zero into lo and the remainder into hi, with the remainder taking the sign of the dividend; DIVU SHALL be unsigned.
REQ-020 DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000.
REQ-021 Divide by zero (b==0) SHALL run the full DIV_CYCLES busy period and leave hi/lo unchanged at completion.
REQ-022 In IDLE, start=1 with MTHI SHALL write hi<=a at that edge; MTLO SHALL write lo<=a; neither SHALL assert busy.
REQ-023 start=1 while in BUSY SHALL be ignored: no capture, no counter reload, no hi/lo write.
REQ-024 start=1 with a reserved op SHALL be ignored in any state.
REQ-025 On the completion edge (counter==1), a simultaneous start SHALL be ignored; a new operation is accepted only from IDLE.
REQ-026 Operands SHALL be sampled only at the accepting edge; changes on a/b during BUSY SHALL NOT affect the result.

Reset
REQ-027 reset=0 SHALL immediately, without waiting for clk, force state=IDLE, counter=0, busy=0, hi=0, lo=0, and pending=0.
REQ-028 Reset asserted during BUSY SHALL abort the operation; the result SHALL NOT be written after reset is released.
REQ-029 After reset deasserts, the first edge with start=1 and a valid op SHALL be accepted normally.

Verification
REQ-030 MULT with a=0xFFFFFFFF, b=0x00000002 -> busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-031 MULTU with the same operands -> after 5 busy cycles, hi=0x00000001, lo=0xFFFFFFFE.
REQ-032 DIV with a=0xFFFFFFF9 (-7), b=2 -> busy for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU with a=7, b=0 -> busy for 10 cycles, hi/lo unchanged.
REQ-033 MTHI with a=0x12345678, then a MULT pulse during BUSY, plus a/b toggling -> hi=0x12345678 the next cycle; only the first operation's result is written.
REQ-034 Reset pulled low asynchronously in the 3rd busy cycle of a DIV -> busy, hi, and lo drop to 0 before the next edge and stay 0 after release.
